dual_port_ram_be: RTL and testbench

Parametrised true dual-port RAM with per-byte write enables, selectable read-during-write mode, optional output register stage and a built-in post-reset clearing sweep. It is the next-generation storage primitive under the cache and scratchpad blocks. It replaces the plain word-write dual-port RAM wherever partial-word stores, a deterministic zeroed state after reset, or pipelined reads are needed.

---
 rtl/dual_port_ram_be.sv | 174 +++++++++++++++++
 tb/tb_dual_port_ram_be.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: true dual-port RAM with per-byte write enables, selectable
// read-during-write result, optional output register and a post-reset sweep
// that zeroes every word before requests are accepted.
// Optional feature macro: DUAL_PORT_RAM_BE_COLLISION_EN adds the registered
// `collision` output flagging overlapping same-address writes.
module dual_port_ram_be #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BYTE_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned INDEX_BITS    = 8,
    parameter string       RW_MODE       = "OLD_DATA",
    parameter int unsigned OUT_REG       = 0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    output logic                                 init_busy,
    input  logic                                 readEnable_0,
    input  logic                                 readEnable_1,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     writeEnable_0,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     writeEnable_1,
    input  logic [DATA_WIDTH-1:0]                writeData_0,
    input  logic [DATA_WIDTH-1:0]                writeData_1,
    input  logic [ADDRESS_WIDTH-1:0]             address_0,
    input  logic [ADDRESS_WIDTH-1:0]             address_1,
    output logic [DATA_WIDTH-1:0]                readData_0,
    output logic [DATA_WIDTH-1:0]                readData_1,
    output logic                                 readValid_0,
`ifdef DUAL_PORT_RAM_BE_COLLISION_EN
    output logic                                 readValid_1,
    output logic                                 collision
`else
    output logic                                 readValid_1
`endif
);

    localparam int unsigned NB       = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH    = 2 ** INDEX_BITS;
    localparam bit          NEW_DATA = (RW_MODE == "NEW_DATA");

    typedef enum logic [1:0] {
        ST_RESET,
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [INDEX_BITS-1:0]           clr_ptr;
    logic [DATA_WIDTH-1:0]           mem [DEPTH];

    logic                            accept_c;
    logic [1:0]                      re;
    logic [1:0][NB-1:0]              we;
    logic [1:0][DATA_WIDTH-1:0]      wd;
    logic [1:0][INDEX_BITS-1:0]      idx;
    logic [1:0][DATA_WIDTH-1:0]      merged_c;
    logic [1:0][DATA_WIDTH-1:0]      rd_word_c;

    logic [1:0]                      s1_valid;
    logic [1:0][DATA_WIDTH-1:0]      s1_data;

    assign re       = {readEnable_1, readEnable_0};
    assign we[0]    = writeEnable_0;
    assign we[1]    = writeEnable_1;
    assign wd[0]    = writeData_0;
    assign wd[1]    = writeData_1;
    assign idx[0]   = address_0[INDEX_BITS-1:0];
    assign idx[1]   = address_1[INDEX_BITS-1:0];
    assign accept_c = reset && (state == ST_READY);

    // Upper address bits are deliberately ignored so addresses wrap modulo depth.
    if (ADDRESS_WIDTH > INDEX_BITS) begin : g_addr_wrap
        logic unused_addr_hi;
        assign unused_addr_hi = ^{address_0[ADDRESS_WIDTH-1:INDEX_BITS],
                                  address_1[ADDRESS_WIDTH-1:INDEX_BITS]};
    end

    // Next state: one cycle in RESET, DEPTH clear writes, then READY.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_RESET: state_next = ST_CLEAR;
            ST_CLEAR: if (&clr_ptr) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_RESET;
        endcase
    end

    // State register, clear pointer and busy flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_RESET;
            clr_ptr   <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_next;
            init_busy <= (state_next != ST_READY);
            if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Word at each port's address with both ports' enabled lanes applied; port 1 wins shared lanes.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            merged_c[p] = mem[idx[p]];
            for (int unsigned q = 0; q < 2; q++) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (we[q][b] && (idx[q] == idx[p])) begin
                        merged_c[p][b*BYTE_WIDTH +: BYTE_WIDTH] = wd[q][b*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
            rd_word_c[p] = NEW_DATA ? merged_c[p] : mem[idx[p]];
        end
    end

    // Storage: sweep zeroes, then merged byte-lane writes (same address yields identical words).
    always_ff @(posedge clock) begin
        if (reset && (state == ST_CLEAR)) begin
            mem[clr_ptr] <= '0;
        end else if (accept_c) begin
            if (|we[0]) mem[idx[0]] <= merged_c[0];
            if (|we[1]) mem[idx[1]] <= merged_c[1];
        end
    end

    // First read stage: data held between valid reads.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= {accept_c & re[1], accept_c & re[0]};
            if (accept_c && re[0]) s1_data[0] <= rd_word_c[0];
            if (accept_c && re[1]) s1_data[1] <= rd_word_c[1];
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [1:0]                 s2_valid;
        logic [1:0][DATA_WIDTH-1:0] s2_data;

        // Optional output stage adding one cycle of read latency.
        always_ff @(posedge clock) begin
            if (!reset) begin
                s2_valid <= '0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid[0]) s2_data[0] <= s1_data[0];
                if (s1_valid[1]) s2_data[1] <= s1_data[1];
            end
        end

        assign readValid_0 = s2_valid[0];
        assign readValid_1 = s2_valid[1];
        assign readData_0  = s2_data[0];
        assign readData_1  = s2_data[1];
    end else begin : g_no_out_reg
        assign readValid_0 = s1_valid[0];
        assign readValid_1 = s1_valid[1];
        assign readData_0  = s1_data[0];
        assign readData_1  = s1_data[1];
    end

`ifdef DUAL_PORT_RAM_BE_COLLISION_EN
    // Flag same-address writes whose byte enables overlap.
    always_ff @(posedge clock) begin
        if (!reset) collision <= 1'b0;
        else        collision <= accept_c && (idx[0] == idx[1]) && (|(we[0] & we[1]));
    end
`endif

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: three instances (OLD_DATA, NEW_DATA, OLD_DATA with
// output register) share one stimulus stream; a word-level model predicts
// every output each cycle, and directed points carry literal expectations.
module tb_dual_port_ram_be;

    localparam int unsigned DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        re0 = 1'b0, re1 = 1'b0;
    logic [3:0]  we0 = '0, we1 = '0;
    logic [31:0] wd0 = '0, wd1 = '0, a0 = '0, a1 = '0;

    logic        busy [3];
    logic        rv   [3][2];
    logic [31:0] rdat [3][2];
`ifdef DUAL_PORT_RAM_BE_COLLISION_EN
    logic        coll [3];
`endif

    int n_vec = 0;
    int n_mis = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dual_port_ram_be #(
            .DATA_WIDTH   (32),
            .BYTE_WIDTH   (8),
            .ADDRESS_WIDTH(32),
            .INDEX_BITS   (4),
            .RW_MODE      (g == 1 ? "NEW_DATA" : "OLD_DATA"),
            .OUT_REG      (g == 2 ? 1 : 0)
        ) u_dut (
            .clock        (clock),
            .reset        (reset),
            .init_busy    (busy[g]),
            .readEnable_0 (re0),
            .readEnable_1 (re1),
            .writeEnable_0(we0),
            .writeEnable_1(we1),
            .writeData_0  (wd0),
            .writeData_1  (wd1),
            .address_0    (a0),
            .address_1    (a1),
            .readData_0   (rdat[g][0]),
            .readData_1   (rdat[g][1]),
            .readValid_0  (rv[g][0]),
`ifdef DUAL_PORT_RAM_BE_COLLISION_EN
            .readValid_1  (rv[g][1]),
            .collision    (coll[g])
`else
            .readValid_1  (rv[g][1])
`endif
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    int          m_cnt = 0;
    bit          exp_busy = 1'b1;
    bit          exp_valid [3][2];
    logic [31:0] exp_data  [3][2];
    bit          p2_valid  [2];
    logic [31:0] p2_data   [2];
    bit          exp_coll = 1'b0;

    always @(posedge clock) begin
        logic [31:0] oldw [2];
        logic [31:0] neww [2];
        logic [3:0]  ix   [2];
        logic [3:0]  wm   [2];
        logic [31:0] wdat [2];
        bit          rd   [2];
        bit          acc;
        acc     = reset && !exp_busy;
        ix[0]   = a0[3:0];  ix[1]   = a1[3:0];
        wm[0]   = we0;      wm[1]   = we1;
        wdat[0] = wd0;      wdat[1] = wd1;
        rd[0]   = acc && re0;
        rd[1]   = acc && re1;
        if (!reset) begin
            m_cnt    = 0;
            exp_busy = 1'b1;
            exp_coll = 1'b0;
            for (int i = 0; i < 3; i++)
                for (int p = 0; p < 2; p++) begin
                    exp_valid[i][p] = 1'b0;
                    exp_data[i][p]  = '0;
                end
            for (int p = 0; p < 2; p++) begin
                p2_valid[p] = 1'b0;
                p2_data[p]  = '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) oldw[p] = m_mem[ix[p]];
            if (acc) begin
                // port 0 lanes first, port 1 lanes last so port 1 wins shared lanes
                for (int q = 0; q < 2; q++)
                    for (int b = 0; b < 4; b++)
                        if (wm[q][b]) m_mem[ix[q]][8*b +: 8] = wdat[q][8*b +: 8];
            end
            for (int p = 0; p < 2; p++) neww[p] = m_mem[ix[p]];
            exp_coll = acc && (ix[0] == ix[1]) && ((wm[0] & wm[1]) != 4'b0);
            for (int p = 0; p < 2; p++) begin
                exp_valid[2][p] = p2_valid[p];
                if (p2_valid[p]) exp_data[2][p] = p2_data[p];
                p2_valid[p] = rd[p];
                if (rd[p]) p2_data[p] = oldw[p];
                exp_valid[0][p] = rd[p];
                exp_valid[1][p] = rd[p];
                if (rd[p]) begin
                    exp_data[0][p] = oldw[p];
                    exp_data[1][p] = neww[p];
                end
            end
            if (exp_busy) begin
                m_cnt++;
                if (m_cnt > DEPTH) begin
                    exp_busy = 1'b0;
                    for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
                end
            end
        end
    end

    // Compare every output of every instance against the model on each falling edge.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(exp_busy));
            for (int p = 0; p < 2; p++) begin
                check($sformatf("valid[%0d][%0d]", i, p), 32'(rv[i][p]), 32'(exp_valid[i][p]));
                check($sformatf("data[%0d][%0d]", i, p), rdat[i][p], exp_data[i][p]);
            end
`ifdef DUAL_PORT_RAM_BE_COLLISION_EN
            check($sformatf("collision[%0d]", i), 32'(coll[i]), 32'(exp_coll));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clock);
    endtask

    task automatic idle();
        re0 = 1'b0; re1 = 1'b0; we0 = '0; we1 = '0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (3) step();
        check("rst_busy", 32'(busy[0]), 32'd1);
        check("rst_valid", 32'(rv[2][0]), 32'd0);
        check("rst_data", rdat[1][1], 32'h0);

        // release; requests during the sweep must be ignored
        reset = 1'b1;
        re0 = 1'b1; a0 = 32'd0; we1 = 4'hF; wd1 = 32'hDEAD_BEEF; a1 = 32'd2;
        for (int i = 0; i <= 16; i++) begin
            step();
            check($sformatf("sweep_busy_%0d", i), 32'(busy[0]), (i < 16) ? 32'd1 : 32'd0);
        end

        // first READY cycle accepts; whole array reads zero
        idle();
        for (int i = 0; i < 16; i++) begin
            re0 = 1'b1; a0 = 32'(i);
            re1 = 1'b1; a1 = 32'(15 - i);
            step();
            check($sformatf("clr_valid_%0d", i), 32'(rv[0][0]), 32'd1);
            check($sformatf("clr_data_%0d", i), rdat[0][0], 32'h0);
        end

        // byte-enable merge, read via wrapped address 0x13
        idle(); we0 = 4'hF; wd0 = 32'hAABB_CCDD; a0 = 32'd3; step();
        we0 = 4'b0010; wd0 = 32'h0000_1100; step();
        idle(); re1 = 1'b1; a1 = 32'h0000_0013; step();
        check("be_merge_old", rdat[0][1], 32'hAABB_11DD);
        check("be_merge_new", rdat[1][1], 32'hAABB_11DD);

        // cross-port read during write
        idle(); we0 = 4'hF; wd0 = 32'h49; a0 = 32'd14; step();
        idle(); we1 = 4'hF; wd1 = 32'h53; a1 = 32'd14; re0 = 1'b1; a0 = 32'd14; step();
        check("rdw_old", rdat[0][0], 32'h49);
        check("rdw_new", rdat[1][0], 32'h53);
        idle(); re0 = 1'b1; re1 = 1'b1; a0 = 32'd14; a1 = 32'd14; step();
        check("rdw_after_old_p0", rdat[0][0], 32'h53);
        check("rdw_after_old_p1", rdat[0][1], 32'h53);
        check("rdw_after_new_p0", rdat[1][0], 32'h53);
        check("rdw_after_new_p1", rdat[1][1], 32'h53);
        check("rdw_reg_old", rdat[2][0], 32'h49);
        idle(); step();
        check("rdw_reg_after_p0", rdat[2][0], 32'h53);
        check("rdw_reg_after_p1", rdat[2][1], 32'h53);

        // same-port read and write
        idle(); re0 = 1'b1; we0 = 4'hF; wd0 = 32'h77; a0 = 32'd7; step();
        check("same_port_old", rdat[0][0], 32'h0);
        check("same_port_new", rdat[1][0], 32'h77);

        // write-write collision with overlapping lanes
        idle(); we0 = 4'hF; wd0 = 32'h1111_1111; a0 = 32'd5;
        we1 = 4'b0011; wd1 = 32'h2222_2222; a1 = 32'd5; step();
`ifdef DUAL_PORT_RAM_BE_COLLISION_EN
        check("coll_pulse", 32'(coll[0]), 32'd1);
`endif
        idle(); re0 = 1'b1; a0 = 32'd5; step();
        check("ww_merge", rdat[0][0], 32'h1111_2222);
`ifdef DUAL_PORT_RAM_BE_COLLISION_EN
        check("coll_drop", 32'(coll[0]), 32'd0);
`endif

        // same address, disjoint lanes (0x19 wraps to 9): merge without collision
        idle(); we0 = 4'b1100; wd0 = 32'h3333_3333; a0 = 32'd9;
        we1 = 4'b0011; wd1 = 32'h4444_4444; a1 = 32'h19; step();
        idle(); re1 = 1'b1; a1 = 32'd9; step();
        check("disjoint_merge", rdat[0][1], 32'h3333_4444);

        // pipelined reads through the output-register instance
        idle(); we0 = 4'hF; wd0 = 32'hA; a0 = 32'd1; we1 = 4'hF; wd1 = 32'hB; a1 = 32'd2; step();
        idle(); we0 = 4'hF; wd0 = 32'hC; a0 = 32'd3; step();
        idle(); re0 = 1'b1; a0 = 32'd1; step();
        check("pipe_lat", 32'(rv[2][0]), 32'd0);
        a0 = 32'd2; step();
        check("pipe_v1", 32'(rv[2][0]), 32'd1);
        check("pipe_d1", rdat[2][0], 32'hA);
        a0 = 32'd3; step();
        check("pipe_v2", 32'(rv[2][0]), 32'd1);
        check("pipe_d2", rdat[2][0], 32'hB);
        idle(); step();
        check("pipe_v3", 32'(rv[2][0]), 32'd1);
        check("pipe_d3", rdat[2][0], 32'hC);
        step();
        check("pipe_end", 32'(rv[2][0]), 32'd0);
        check("pipe_hold", rdat[2][0], 32'hC);

        // reset while a registered read is in flight
        idle(); re0 = 1'b1; a0 = 32'd3; re1 = 1'b1; a1 = 32'd1; step();
        idle(); reset = 1'b0; step();
        check("flush_valid", 32'(rv[2][0]), 32'd0);
        check("flush_data", rdat[2][0], 32'h0);

        // reset mid-sweep, then a full sweep again with requests held
        reset = 1'b1; repeat (8) step();
        reset = 1'b0; step();
        reset = 1'b1; re0 = 1'b1; a0 = 32'd3; re1 = 1'b1; a1 = 32'd9;
        for (int i = 0; i <= 16; i++) begin
            step();
            check($sformatf("resweep_busy_%0d", i), 32'(busy[0]), (i < 16) ? 32'd1 : 32'd0);
            if (i < 16) check($sformatf("resweep_novalid_%0d", i), 32'(rv[0][0]), 32'd0);
        end
        step();
        check("post_clear_valid", 32'(rv[0][0]), 32'd1);
        check("post_clear_a3", rdat[0][0], 32'h0);
        check("post_clear_a9", rdat[1][1], 32'h0);
        idle(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
